// File: rtl/mult_pkg.sv
// Shared definitions for the Booth-4/Wallace signed multiplier datapath.
// Holds the default operand width, product width and the sign/magnitude payload record.
package mult_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PROD_W     = 2 * DATA_W_DEF;

  // Largest legal magnitude: (-2^(DATA_W-1))^2
  localparam logic [PROD_W-1:0] MAG_MAX = {2'b01, {(PROD_W-2){1'b0}}};

  typedef struct packed {
    logic [PROD_W-1:0] mag;
    logic              sign;
  } payload_t;

endpackage

// File: rtl/pp_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer: main register M plus skid register K.
// in_ready is registered (~K full), so upstream never sees a combinational ready path.
module pp_skid_buffer #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] m_data_p0, k_data_p0;
  logic         m_vld_p0,  k_vld_p0;
  logic         m_vld_nxt, k_vld_nxt;
  logic         m_load_in, m_load_k, k_load;
  logic         in_xfer;
  logic         rdy_q;

  assign in_xfer   = in_valid & rdy_q;
  assign in_ready  = rdy_q;
  assign out_valid = m_vld_p0;
  assign out_data  = m_data_p0;

  // K can only be full while M is full, and while K is full no input is accepted.
  always_comb begin
    m_vld_nxt = m_vld_p0;
    k_vld_nxt = k_vld_p0;
    m_load_in = 1'b0;
    m_load_k  = 1'b0;
    k_load    = 1'b0;
    if (m_vld_p0 && out_ready) begin
      if (k_vld_p0) begin
        m_load_k  = 1'b1;
        k_vld_nxt = 1'b0;
      end else if (in_xfer) begin
        m_load_in = 1'b1;
      end else begin
        m_vld_nxt = 1'b0;
      end
    end else if (m_vld_p0) begin
      if (in_xfer) begin
        k_load    = 1'b1;
        k_vld_nxt = 1'b1;
      end
    end else if (in_xfer) begin
      m_load_in = 1'b1;
      m_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_p0 <= 1'b0;
      k_vld_p0 <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      m_vld_p0 <= m_vld_nxt;
      k_vld_p0 <= k_vld_nxt;
      rdy_q    <= ~k_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (m_load_k) begin
      m_data_p0 <= k_data_p0;
    end else if (m_load_in) begin
      m_data_p0 <= in_data;
    end
    if (k_load) begin
      k_data_p0 <= in_data;
    end
  end

endmodule

// File: rtl/num_postprocessor.sv
// Output end of the signed multiplier: turns {magnitude, sign} into a two's-complement
// product behind a skid-buffered input and a registered valid/ready output.
module num_postprocessor
  import mult_pkg::*;
#(
  parameter int DATA_W = mult_pkg::DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  mag_valid,
  output logic                  mag_ready,
  input  logic [2*DATA_W-1:0]   mag_in,
  input  logic                  sign_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*DATA_W-1:0]   res_data,
  output logic                  res_err,
  output logic [CNT_W-1:0]      res_cnt
);

  localparam int PW = 2 * DATA_W;
  localparam logic [PW-1:0] MAG_LIM = {2'b01, {(PW-2){1'b0}}};

  // Zero magnitude never produces a negative zero.
  function automatic logic signed [PW-1:0] apply_sign(input logic [PW-1:0] mag,
                                                      input logic          sign);
    if (mag == '0)  return '0;
    else if (sign)  return $signed(~mag + PW'(1));
    else            return $signed(mag);
  endfunction

  function automatic logic mag_over(input logic [PW-1:0] mag);
    return mag > MAG_LIM;
  endfunction

  logic [PW:0]          skid_in, skid_out;
  logic                 m_vld_p0;
  logic                 adv_p0;
  logic [PW-1:0]        m_mag_p0;
  logic                 m_sign_p0;
  logic signed [PW-1:0] res_data_p1;
  logic                 res_err_p1;
  logic                 vld_p1;
  logic [CNT_W-1:0]     cnt_q;

  assign skid_in   = {mag_in, sign_in};
  assign m_mag_p0  = skid_out[PW:1];
  assign m_sign_p0 = skid_out[0];
  assign adv_p0    = ~vld_p1 | res_ready;

  pp_skid_buffer #(.W(PW + 1)) u_skid (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .in_valid  (mag_valid),
    .in_ready  (mag_ready),
    .in_data   (skid_in),
    .out_valid (m_vld_p0),
    .out_ready (adv_p0),
    .out_data  (skid_out)
  );

  // Stage p0 -> p1: sign application and range check into the output register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_p1      <= 1'b0;
      res_data_p1 <= '0;
      res_err_p1  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (adv_p0) begin
        vld_p1 <= m_vld_p0;
        if (m_vld_p0) begin
          res_data_p1 <= apply_sign(m_mag_p0, m_sign_p0);
          res_err_p1  <= mag_over(m_mag_p0);
        end
      end
      if (vld_p1 && res_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign res_valid = vld_p1;
  assign res_data  = res_data_p1;
  assign res_err   = res_err_p1;
  assign res_cnt   = cnt_q;

endmodule
